// File: rtl/relu_backward_if.sv
// mem_handle: one-word-per-transaction memory port shared by the FPU layer chain.
// The master holds r_en/w_en with avail until done, then drops and bumps ptr.
interface mem_handle;
  logic        r_en;
  logic        w_en;
  logic        avail;
  logic [31:0] ptr;
  logic [31:0] data_store;
  logic [31:0] data_load;
  logic        done;
  logic [31:0] region_end;

  modport master (
    output r_en, w_en, avail, ptr, data_store,
    input  data_load, done, region_end
  );

  modport slave (
    input  r_en, w_en, avail, ptr, data_store,
    output data_load, done, region_end
  );
endinterface

// File: rtl/relu_backward.sv
// relu_backward: dX = (X > 0) ? dY : +0.0, streamed word by word over mem_handle ports.
// Optional RELU_BW_SHAPE_CHECK_EN compares the dY and X headers and raises err.
module relu_backward (
  input  logic clk,
  input  logic rst_l,
  mem_handle.master a,
  mem_handle.master b,
  mem_handle.master c,
  mem_handle.master d,
  input  logic go,
`ifdef RELU_BW_SHAPE_CHECK_EN
  output logic done,
  output logic err
`else
  output logic done
`endif
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_HDR_RD,
    S_HDR_WR,
    S_LOOP,
    S_RD_A,
    S_RD_B,
    S_WR,
    S_DONE
  } state_t;

  state_t      state;
  logic        a_req;
  logic        b_req;
  logic        d_req;
  logic [31:0] a_ptr;
  logic [31:0] b_ptr;
  logic [31:0] d_ptr;
  logic [31:0] d_wdata;
  logic [31:0] g;
  logic [1:0]  hcnt;
  logic [1:0]  hlen;
  logic [1:0]  hcnt_nx;
  logic        a_hit;
  logic        b_hit;
  logic        d_hit;

  function automatic logic [1:0] hlen_of(input logic [31:0] w);
    return (w == 32'd1) ? 2'd2 : 2'd3;
  endfunction

  // Strictly positive: sign clear and not a zero pattern (NaN/Inf included).
  function automatic logic pass(input logic [31:0] x);
    return !x[31] && (x[30:0] != 31'd0);
  endfunction

  assign a_hit   = a_req & a.done;
  assign b_hit   = b_req & b.done;
  assign d_hit   = d_req & d.done;
  assign hcnt_nx = hcnt + 2'd1;

  assign a.r_en       = a_req;
  assign a.avail      = a_req;
  assign a.w_en       = 1'b0;
  assign a.ptr        = a_ptr;
  assign a.data_store = 32'h0;

  assign b.r_en       = b_req;
  assign b.avail      = b_req;
  assign b.w_en       = 1'b0;
  assign b.ptr        = b_ptr;
  assign b.data_store = 32'h0;

  assign c.r_en       = 1'b0;
  assign c.w_en       = 1'b0;
  assign c.avail      = 1'b0;
  assign c.ptr        = 32'h0;
  assign c.data_store = 32'h0;

  assign d.r_en       = 1'b0;
  assign d.w_en       = d_req;
  assign d.avail      = d_req;
  assign d.ptr        = d_ptr;
  assign d.data_store = d_wdata;

  assign done = (state == S_DONE);

  logic unused_ok;
  assign unused_ok = ^{a.region_end, b.region_end,
                       c.data_load, c.done, c.region_end,
                       d.data_load};

`ifdef RELU_BW_SHAPE_CHECK_EN
  logic        a_got;
  logic        b_got;
  logic        err_q;
  logic [31:0] hword_a;
  logic [31:0] hword_b;
  logic [31:0] wa;
  logic [31:0] wb;
  logic        a_fin;
  logic        b_fin;

  assign wa    = a_hit ? a.data_load : hword_a;
  assign wb    = b_hit ? b.data_load : hword_b;
  assign a_fin = a_got | a_hit;
  assign b_fin = b_got | b_hit;
  assign err   = err_q;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state   <= S_WAIT;
      a_req   <= 1'b0;
      b_req   <= 1'b0;
      d_req   <= 1'b0;
      a_ptr   <= 32'h0;
      b_ptr   <= 32'h0;
      d_ptr   <= 32'h0;
      d_wdata <= 32'h0;
      g       <= 32'h0;
      hcnt    <= 2'd0;
      hlen    <= 2'd0;
`ifdef RELU_BW_SHAPE_CHECK_EN
      a_got   <= 1'b0;
      b_got   <= 1'b0;
      err_q   <= 1'b0;
      hword_a <= 32'h0;
      hword_b <= 32'h0;
`endif
    end else begin
      unique case (state)
        S_WAIT: begin
          if (go) begin
            a_ptr <= 32'h0;
            b_ptr <= 32'h0;
            d_ptr <= 32'h0;
            hcnt  <= 2'd0;
            a_req <= 1'b1;
`ifdef RELU_BW_SHAPE_CHECK_EN
            b_req <= 1'b1;
            a_got <= 1'b0;
            b_got <= 1'b0;
            err_q <= 1'b0;
`endif
            state <= S_HDR_RD;
          end
        end
        S_HDR_RD: begin
`ifdef RELU_BW_SHAPE_CHECK_EN
          if (a_hit) begin
            a_req   <= 1'b0;
            a_ptr   <= a_ptr + 32'd1;
            hword_a <= a.data_load;
            a_got   <= 1'b1;
          end
          if (b_hit) begin
            b_req   <= 1'b0;
            b_ptr   <= b_ptr + 32'd1;
            hword_b <= b.data_load;
            b_got   <= 1'b1;
          end
          if (a_fin && b_fin) begin
            a_got <= 1'b0;
            b_got <= 1'b0;
            if (wa != wb) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              if (hcnt == 2'd0) hlen <= hlen_of(wa);
              d_req   <= 1'b1;
              d_wdata <= wa;
              state   <= S_HDR_WR;
            end
          end
`else
          if (a_hit) begin
            a_req <= 1'b0;
            a_ptr <= a_ptr + 32'd1;
            if (hcnt == 2'd0) hlen <= hlen_of(a.data_load);
            d_req   <= 1'b1;
            d_wdata <= a.data_load;
            state   <= S_HDR_WR;
          end
`endif
        end
        S_HDR_WR: begin
          if (d_hit) begin
            d_req <= 1'b0;
            d_ptr <= d_ptr + 32'd1;
            hcnt  <= hcnt_nx;
            if (hcnt_nx < hlen) begin
              a_req <= 1'b1;
`ifdef RELU_BW_SHAPE_CHECK_EN
              b_req <= 1'b1;
`endif
              state <= S_HDR_RD;
            end else begin
`ifndef RELU_BW_SHAPE_CHECK_EN
              b_ptr <= {30'd0, hlen};
`endif
              state <= S_LOOP;
            end
          end
        end
        S_LOOP: begin
          if (d_ptr == d.region_end) begin
            state <= S_DONE;
          end else begin
            a_req <= 1'b1;
            state <= S_RD_A;
          end
        end
        S_RD_A: begin
          if (a_hit) begin
            a_req <= 1'b0;
            a_ptr <= a_ptr + 32'd1;
            g     <= a.data_load;
            b_req <= 1'b1;
            state <= S_RD_B;
          end
        end
        S_RD_B: begin
          if (b_hit) begin
            b_req   <= 1'b0;
            b_ptr   <= b_ptr + 32'd1;
            d_req   <= 1'b1;
            d_wdata <= pass(b.data_load) ? g : 32'h0;
            state   <= S_WR;
          end
        end
        S_WR: begin
          if (d_hit) begin
            d_req <= 1'b0;
            d_ptr <= d_ptr + 32'd1;
            state <= S_LOOP;
          end
        end
        S_DONE: begin
          if (!go) state <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: doc/relu_backward.md
# relu_backward

Backward-pass ReLU stage in the FPU layer chain: consumes the upstream gradient tensor dY and the forward-pass input tensor X, and produces dX = dY where X > 0, else +0.0. It sits directly downstream of the forward ReLU in the training schedule: its X operand is the tensor the forward stage read, and its output feeds the preceding layer's backward stage. The block talks to memory only through `mem_handle` ports, one 32-bit word per transaction.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst_l`  in  1  asynchronous, active-low reset.
- `a`  mem_handle  —  dY tensor, read-only.
- `b`  mem_handle  —  X tensor, read-only.
- `c`  mem_handle  —  unused; control signals held at 0.
- `d`  mem_handle  —  dX tensor, write-only; `d.region_end` terminates the operation.
- `go`  in  1  level start request from the scheduler.
- `done`  out  1  high exactly while the FSM is in DONE.
- `err`  out  1  shape mismatch flag; present only with `RELU_BW_SHAPE_CHECK_EN`.

## Operation
- Tensor layout:
  - Word 0 is `ndim`. Value 1 means 1 dim word follows; any other value means 2 dim words follow.
  - Data words follow the header, IEEE-754 single precision.
- Memory handshake, per handle:
  - Assert `r_en` or `w_en` together with `avail`. For writes, `data_store` must be valid at the same time.
  - Hold until `done` = 1. `data_load` is valid in that cycle.
  - In that same cycle, drop `r_en`/`w_en`/`avail` and increment `ptr`.
  - No two transactions on one handle overlap.
- States: WAIT, HDR_RD, HDR_WR, LOOP, RD_A, RD_B, WR, DONE.
- WAIT:
  - `go` = 1 clears `a.ptr`, `b.ptr`, `d.ptr` and the header counter `hcnt`, then moves to HDR_RD.
- HDR_RD:
  - Reads one word from `a`.
  - When `hcnt` = 0, the word also sets header length `hlen` = (word == 1) ? 2 : 3.
- HDR_WR:
  - Writes the latched word to `d` and increments `hcnt`.
  - Next state is HDR_RD if `hcnt+1 < hlen`, else LOOP.
  - On leaving, `b.ptr` is set to `hlen` (X header skipped, not read).
- LOOP:
  - One cycle, no memory activity.
  - `d.ptr == d.region_end` → DONE; otherwise → RD_A.
- RD_A: reads g from `a`, then → RD_B.
- RD_B: reads x from `b`, then → WR.
- WR:
  - Writes `(x[31]==0 && x[30:0]!=0) ? g : 32'h0000_0000`, then → LOOP.
  - Every data word is written, including zeros.
- Value rules:
  - −0.0 and +0.0 both block the gradient.
  - Any positive-sign pattern, including +Inf and +NaN, passes g bit-exact.
  - Negative NaN blocks the gradient.
  - No arithmetic is performed.
- DONE:
  - Stays while `go` = 1; returns to WAIT when `go` = 0.
  - Pointers hold their final values until the next `go`.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - FSM → WAIT.
  - All `r_en`/`w_en`/`avail` = 0, all `ptr` = 0, all `data_store` = 0.
  - `done` = 0, `err` = 0.
  - An in-flight memory request is abandoned.
- `go` is sampled only in WAIT and DONE. Deasserting `go` mid-operation has no effect.
- Request assertion:
  - Requests assert in the first cycle of HDR_RD/HDR_WR/RD_A/RD_B/WR.
  - A `done` in the same cycle as a newly registered request is not possible, so minimum residency is 2 cycles per memory state.
- Per-element cost, with 1-cycle memory latency: LOOP 1 + RD_A 2 + RD_B 2 + WR 2 = 7 cycles.
- Header costs 4 cycles per word.
- `d.region_end` == header end (empty tensor) → DONE directly after the last header write, with zero data transactions.
- `d.region_end` is compared only in LOOP; an in-flight element always completes.

## Configuration
- `RELU_BW_SHAPE_CHECK_EN` defined:
  - HDR_RD also reads the same-index word from `b`; both handshakes must complete before leaving.
  - `b.ptr` advances naturally instead of being set to `hlen`.
  - Any differing header word sets `err` = 1 and goes to DONE without writing that word.
  - `err` clears on the next `go` accepted in WAIT.
- Undefined:
  - `b` header is never read, and the `err` port does not exist.

## Test plan
- 1-D tensor [1, 4 | 1.0, −2.0, 0.0, 3.5] for X, dY [1, 4 | 0.5, 0.5, 0.5, 0.5] → d = [1, 4 | 0x3F000000, 0, 0, 0x3F000000]; `done` rises, falls one cycle after `go` drops.
- 2-D X [2, 2, 2 | −0.0 (0x80000000), +Inf, 0x7FC00000, 0xFFC00000] → dX passes only words 2 and 3 of dY; −0.0 and −NaN give 0.
- `d.region_end` = 2 with 1-D header, no data → 2 header writes, 0 reads on `b`, DONE.
- Memory `done` delayed 5 cycles on `b` only → output identical to zero-stall run; `a.r_en` never overlaps with itself.
- `rst_l` pulsed low during WR of element 3 → all controls 0, `done` 0 immediately; re-`go` rewrites full output from ptr 0.
- With `RELU_BW_SHAPE_CHECK_EN`: X header [2, 3, 4], dY header [2, 3, 5] → `err` = 1, DONE, `d` holds only words 0–1.
